ayatsuki_dmem_mmio: RTL and testbench

//   Data-side memory subsystem downstream of the ayatsuki_core data port.

---
 rtl/ayatsuki_dmem_mmio_if.sv | 30 +++
 rtl/ayatsuki_dmem_mmio.sv | 143 ++++++++++++++
 tb/tb_ayatsuki_dmem_mmio.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ayatsuki_dmem_mmio_if.sv
// Core data-port bus between ayatsuki_core and the data memory / MMIO subsystem.
interface ayatsuki_dmem_mmio_if;
    logic        mem_enable_i;
    logic        mem_r_enable_i;
    logic        mem_w_enable_i;
    logic [31:0] mem_r_addr_i;
    logic [31:0] mem_w_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;

    modport master (
        output mem_enable_i,
        output mem_r_enable_i,
        output mem_w_enable_i,
        output mem_r_addr_i,
        output mem_w_addr_i,
        output mem_data_i,
        input  mem_data_o
    );

    modport slave (
        input  mem_enable_i,
        input  mem_r_enable_i,
        input  mem_w_enable_i,
        input  mem_r_addr_i,
        input  mem_w_addr_i,
        input  mem_data_i,
        output mem_data_o
    );
endinterface

// File: rtl/ayatsuki_dmem_mmio.sv
// Data-side memory subsystem: big-endian word RAM plus an MMIO block holding a
// free-running timer with compare interrupt, sticky error status and TOHOST halt.
module ayatsuki_dmem_mmio #(
    parameter int unsigned RAM_BYTES = 2048,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                rst_n,
    ayatsuki_dmem_mmio_if.slave bus,
    output logic                timer_irq_o,
    output logic                err_o,
    output logic                halt_o,
    output logic [31:0]         exit_code_o
);
    localparam int unsigned RAM_WORDS  = RAM_BYTES / 4;
    localparam int unsigned IDX_W      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_LIMIT  = 32'(RAM_BYTES);
    localparam logic [31:0] A_MTIME    = MMIO_BASE;
    localparam logic [31:0] A_MTIMECMP = MMIO_BASE + 32'h4;
    localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'h8;
    localparam logic [31:0] A_TOHOST   = MMIO_BASE + 32'hC;

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        r_irq;
    logic        r_err;
    logic        r_halt;
    logic [31:0] r_exit_code;

    logic             w_rd;
    logic             w_wr;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [31:0]      w_rd_data;
    logic             w_rd_misaligned;
    logic             w_wr_ram;
    logic             w_wr_mtime;
    logic             w_wr_cmp;
    logic             w_wr_status;
    logic             w_wr_tohost;
    logic             w_wr_err;
    logic             w_irq_set;

    assign w_rd     = rst_n & bus.mem_enable_i & bus.mem_r_enable_i;
    assign w_wr     = rst_n & bus.mem_enable_i & bus.mem_w_enable_i & ~r_halt;
    assign w_rd_idx = bus.mem_r_addr_i[IDX_W+1:2];
    assign w_wr_idx = bus.mem_w_addr_i[IDX_W+1:2];

    // Reads see pre-edge state, so a same-cycle write to the same word returns the old value.
    always_comb begin
        w_rd_data       = '0;
        w_rd_misaligned = 1'b0;
        if (w_rd) begin
            if (bus.mem_r_addr_i[1:0] != 2'b00) begin
                w_rd_misaligned = 1'b1;
            end else if (bus.mem_r_addr_i < RAM_LIMIT) begin
                w_rd_data = r_ram[w_rd_idx];
            end else begin
                case (bus.mem_r_addr_i)
                    A_MTIME:    w_rd_data = r_mtime;
                    A_MTIMECMP: w_rd_data = r_mtimecmp;
                    A_STATUS:   w_rd_data = {30'b0, r_err, r_irq};
                    A_TOHOST:   w_rd_data = r_exit_code;
                    default:    w_rd_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        w_wr_ram    = 1'b0;
        w_wr_mtime  = 1'b0;
        w_wr_cmp    = 1'b0;
        w_wr_status = 1'b0;
        w_wr_tohost = 1'b0;
        w_wr_err    = 1'b0;
        if (w_wr) begin
            if (bus.mem_w_addr_i[1:0] != 2'b00) begin
                w_wr_err = 1'b1;
            end else if (bus.mem_w_addr_i < RAM_LIMIT) begin
                w_wr_ram = 1'b1;
            end else begin
                case (bus.mem_w_addr_i)
                    A_MTIME:    w_wr_mtime  = 1'b1;
                    A_MTIMECMP: w_wr_cmp    = 1'b1;
                    A_STATUS:   w_wr_status = 1'b1;
                    A_TOHOST:   w_wr_tohost = 1'b1;
                    default:    w_wr_err    = 1'b1;
                endcase
            end
        end
    end

    // A zero compare value means the interrupt is disarmed.
    assign w_irq_set = (r_mtimecmp != 32'h0) && (r_mtime == r_mtimecmp);

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_wr_idx] <= bus.mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '0;
            r_irq       <= 1'b0;
            r_err       <= 1'b0;
            r_halt      <= 1'b0;
            r_exit_code <= '0;
        end else begin
            if (w_wr_mtime) begin
                r_mtime <= bus.mem_data_i;
            end else if (!r_halt) begin
                r_mtime <= r_mtime + 32'h1;
            end
            if (w_wr_cmp) begin
                r_mtimecmp <= bus.mem_data_i;
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (w_wr_status && bus.mem_data_i[0]) begin
                r_irq <= 1'b0;
            end
            if (w_rd_misaligned || w_wr_err) begin
                r_err <= 1'b1;
            end else if (w_wr_status && bus.mem_data_i[1]) begin
                r_err <= 1'b0;
            end
            if (w_wr_tohost) begin
                r_halt      <= 1'b1;
                r_exit_code <= bus.mem_data_i;
            end
        end
    end

    assign bus.mem_data_o = w_rd_data;
    assign timer_irq_o    = r_irq;
    assign err_o          = r_err;
    assign halt_o         = r_halt;
    assign exit_code_o    = r_exit_code;
endmodule

// File: tb/tb_ayatsuki_dmem_mmio.sv
// Directed bench for ayatsuki_dmem_mmio: vector table for RAM/status decode plus
// hand sequences for timer compare, wrap, halt and reset.
module tb_ayatsuki_dmem_mmio;
    localparam logic [31:0] A_MTIME    = 32'h0000_1000;
    localparam logic [31:0] A_MTIMECMP = 32'h0000_1004;
    localparam logic [31:0] A_STATUS   = 32'h0000_1008;
    localparam logic [31:0] A_TOHOST   = 32'h0000_100C;

    logic        clk;
    logic        rst_n;
    logic        timer_irq_o;
    logic        err_o;
    logic        halt_o;
    logic [31:0] exit_code_o;

    int n_chk = 0;
    int n_err = 0;

    ayatsuki_dmem_mmio_if bus();

    ayatsuki_dmem_mmio #(
        .RAM_BYTES (2048),
        .MMIO_BASE (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .timer_irq_o (timer_irq_o),
        .err_o       (err_o),
        .halt_o      (halt_o),
        .exit_code_o (exit_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        ren;
        logic        wen;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic ren, logic wen, logic [31:0] ra,
                                logic [31:0] wa, logic [31:0] wd, logic [31:0] er, logic ee);
        vec_t v;
        v = '{en, ren, wen, ra, wa, wd, er, ee};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(logic en, logic ren, logic wen, logic [31:0] ra,
                         logic [31:0] wa, logic [31:0] wd);
        bus.mem_enable_i   = en;
        bus.mem_r_enable_i = ren;
        bus.mem_w_enable_i = wen;
        bus.mem_r_addr_i   = ra;
        bus.mem_w_addr_i   = wa;
        bus.mem_data_i     = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        int          cnt;

        // Reset with a TOHOST write pending: write must be discarded.
        rst_n = 1'b0;
        drive(1, 1, 1, A_MTIME, A_TOHOST, 32'h77);
        step();
        step();
        #1;
        chk("rdata_in_reset", bus.mem_data_o, 32'h0);
        rst_n = 1'b1;
        drive(1, 1, 0, A_MTIME, 32'h0, 32'h0);
        #1;
        chk("mtime_reset", bus.mem_data_o, 32'h0);
        chk("irq_reset", {31'b0, timer_irq_o}, 32'h0);
        chk("err_reset", {31'b0, err_o}, 32'h0);
        chk("halt_reset", {31'b0, halt_o}, 32'h0);
        chk("exit_reset", exit_code_o, 32'h0);
        step();

        //                en ren wen raddr          waddr         wdata          exp_rd         err
        vecs.push_back(mk(1, 0, 1, 32'h0,          32'h0,        32'hDEADBEEF, 32'h0,         0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          32'h0,        32'h0,        32'hDEADBEEF,  0));
        vecs.push_back(mk(1, 1, 0, 32'h2,          32'h0,        32'h0,        32'h0,         1));
        vecs.push_back(mk(1, 0, 1, 32'h0,          A_STATUS,     32'h2,        32'h0,         0));
        vecs.push_back(mk(1, 0, 1, 32'h0,          32'h8,        32'h22,       32'h0,         0));
        vecs.push_back(mk(1, 1, 1, 32'h8,          32'h8,        32'h11,       32'h22,        0));
        vecs.push_back(mk(1, 1, 0, 32'h8,          32'h0,        32'h0,        32'h11,        0));
        vecs.push_back(mk(0, 1, 1, 32'h8,          32'h8,        32'h99,       32'h0,         0));
        vecs.push_back(mk(1, 1, 0, 32'h8,          32'h0,        32'h0,        32'h11,        0));
        vecs.push_back(mk(1, 0, 1, 32'h0,          32'h800,      32'h5,        32'h0,         1));
        vecs.push_back(mk(1, 1, 1, A_STATUS,       A_STATUS,     32'h2,        32'h2,         0));
        vecs.push_back(mk(1, 0, 1, 32'h0,          32'h1010,     32'h1,        32'h0,         1));
        vecs.push_back(mk(1, 1, 0, 32'h1010,       32'h0,        32'h0,        32'h0,         1));
        vecs.push_back(mk(1, 1, 1, A_STATUS,       32'h5,        32'h3,        32'h2,         1));
        vecs.push_back(mk(1, 1, 1, 32'h3,          A_STATUS,     32'h2,        32'h0,         1));
        vecs.push_back(mk(1, 0, 1, 32'h0,          A_STATUS,     32'h2,        32'h0,         0));
        vecs.push_back(mk(1, 0, 1, 32'h0,          32'h7FC,      32'hCAFEF00D, 32'h0,         0));
        vecs.push_back(mk(1, 1, 0, 32'h7FC,        32'h0,        32'h0,        32'hCAFEF00D,  0));
        vecs.push_back(mk(1, 1, 0, A_MTIMECMP,     32'h0,        32'h0,        32'h0,         0));
        vecs.push_back(mk(1, 1, 0, A_TOHOST,       32'h0,        32'h0,        32'h0,         0));
        vecs.push_back(mk(1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,         0));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ren, vecs[i].wen, vecs[i].raddr, vecs[i].waddr, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d_rdata", i), bus.mem_data_o, vecs[i].exp_rd);
            step();
            chk($sformatf("v%0d_err", i), {31'b0, err_o}, {31'b0, vecs[i].exp_err});
        end

        // Big-endian byte placement of word 0.
        drive(1, 1, 0, 32'h0, 32'h0, 32'h0);
        #1;
        tmp = bus.mem_data_o;
        chk("byte0", {24'b0, tmp[31:24]}, 32'hDE);
        chk("byte3", {24'b0, tmp[7:0]}, 32'hEF);
        step();

        // Timer compare: irq rises 6 edges after mtime is loaded with 5.
        drive(1, 0, 1, 32'h0, A_MTIME, 32'h1000);
        step();
        drive(1, 0, 1, 32'h0, A_MTIMECMP, 32'd10);
        step();
        drive(1, 0, 1, 32'h0, A_MTIME, 32'd5);
        step();
        drive(1, 1, 0, A_MTIME, 32'h0, 32'h0);
        #1;
        chk("mtime_load", bus.mem_data_o, 32'd5);
        chk("irq_before", {31'b0, timer_irq_o}, 32'h0);
        cnt = 0;
        while (!timer_irq_o && cnt < 20) begin
            step();
            cnt++;
        end
        chk("irq_latency", cnt, 32'd6);
        drive(1, 0, 1, 32'h0, A_STATUS, 32'h1);
        step();
        chk("irq_w1c", {31'b0, timer_irq_o}, 32'h0);

        // Set and W1C clear on the same edge: set wins.
        drive(1, 0, 1, 32'h0, A_MTIME, 32'd8);
        step();
        drive(1, 0, 0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        drive(1, 0, 1, 32'h0, A_STATUS, 32'h1);
        step();
        chk("irq_set_wins", {31'b0, timer_irq_o}, 32'h1);
        step();
        chk("irq_clear_after", {31'b0, timer_irq_o}, 32'h0);

        // Wrap at 2^32.
        drive(1, 0, 1, 32'h0, A_MTIME, 32'hFFFF_FFFF);
        step();
        drive(1, 1, 0, A_MTIME, 32'h0, 32'h0);
        #1;
        chk("mtime_max", bus.mem_data_o, 32'hFFFF_FFFF);
        step();
        chk("mtime_wrap", bus.mem_data_o, 32'h0);

        // Halt: mtime freezes at 0x101, later writes ignored, reads still served.
        drive(1, 0, 1, 32'h0, 32'h4, 32'hAAAA5555);
        step();
        drive(1, 0, 1, 32'h0, A_MTIME, 32'h100);
        step();
        drive(1, 0, 1, 32'h0, A_TOHOST, 32'h2A);
        step();
        chk("halt_set", {31'b0, halt_o}, 32'h1);
        chk("exit_code", exit_code_o, 32'h2A);
        drive(1, 0, 1, 32'h0, 32'h4, 32'h12345678);
        step();
        drive(1, 0, 1, 32'h0, A_MTIME, 32'h0);
        step();
        drive(1, 0, 1, 32'h0, A_TOHOST, 32'h55);
        step();
        drive(1, 1, 0, 32'h4, 32'h0, 32'h0);
        #1;
        chk("ram_write_after_halt", bus.mem_data_o, 32'hAAAA5555);
        drive(1, 1, 0, A_MTIME, 32'h0, 32'h0);
        #1;
        chk("mtime_frozen_a", bus.mem_data_o, 32'h101);
        step();
        step();
        chk("mtime_frozen_b", bus.mem_data_o, 32'h101);
        chk("exit_code_sticky", exit_code_o, 32'h2A);
        chk("halt_sticky", {31'b0, halt_o}, 32'h1);

        // Reset clears halt and exit code.
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("halt_after_reset", {31'b0, halt_o}, 32'h0);
        chk("exit_after_reset", exit_code_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
